ahb_mtx_input_stage: RTL and testbench

- Master-side input stage of the AHB bus matrix; one instance sits in front of each master port.
- Produces the per-port `req_port` request that the output-stage arbiters consume, and receives back the grant (`addr_granted`).
- If a master issues a transfer while its target output port is not granted, the block holds the address phase in a register and stalls the master through `HREADYOUTS`. It then replays the held transfer once granted and forwards the data-phase response.

---
 rtl/ahb_mtx_input_stage.sv | 174 +++++++++++++++++
 tb/tb_ahb_mtx_input_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_input_stage.sv
// rtl/ahb_mtx_input_stage.sv - AHB bus matrix master-side input stage (hold/replay of ungranted address phases)
//
// Optional feature macro: AHB_MTX_IS_IDLE_REQ_EN
//   defined   : a locked master driving IDLE/BUSY keeps requesting its output port
//   undefined : request is raised only by a held or valid live transfer
//
// One instance sits in front of every master port. When the master issues a
// transfer while the target output port is not granted to it, the address
// phase is captured into a hold register and the master is stalled through
// HREADYOUTS. The held transfer is replayed on the M side once granted, and
// the slave data-phase response is then forwarded back to the master.

module ahb_mtx_input_stage #(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,

  // Master-side address phase
  input  logic          HSELS,
  input  logic [AW-1:0] HADDRS,
  input  logic [1:0]    HTRANSS,
  input  logic          HWRITES,
  input  logic [2:0]    HSIZES,
  input  logic [2:0]    HBURSTS,
  input  logic [3:0]    HPROTS,
  input  logic          HMASTLOCKS,
  input  logic          HREADYS,

  // Master-side response
  output logic          HREADYOUTS,
  output logic          HRESPS,

  // Address phase towards the matrix
  output logic          HSELM,
  output logic [AW-1:0] HADDRM,
  output logic [1:0]    HTRANSM,
  output logic          HWRITEM,
  output logic [2:0]    HSIZEM,
  output logic [2:0]    HBURSTM,
  output logic [3:0]    HPROTM,
  output logic          HMASTLOCKM,

  // Arbitration handshake with the output stages
  output logic          req_port,
  input  logic          addr_granted,

  // Response from the target output port
  input  logic          HREADYM,
  input  logic          HREADYOUTM,
  input  logic          HRESPM
);

  // State encoding is {pend, dphase}; 2'b11 is never entered.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PEND = 2'b10
  } state_t;

  state_t state;

  logic pend;
  logic dphase;

  // Held copy of an address phase that could not be issued when presented
  logic          hold_sel;
  logic [AW-1:0] hold_addr;
  logic [1:0]    hold_trans;
  logic          hold_write;
  logic [2:0]    hold_size;
  logic [2:0]    hold_burst;
  logic [3:0]    hold_prot;
  logic          hold_lock;

  logic live_valid;
  logic issue;
  logic capture;

  assign pend   = (state == ST_PEND);
  assign dphase = (state == ST_DATA);

  // Only NONSEQ/SEQ count; IDLE and BUSY ride the live path and are never held.
  assign live_valid = HSELS & HREADYS & HTRANSS[1];

  // The transfer on the M side (held or live) is accepted by the output stage.
  assign issue = addr_granted & HREADYM & (pend | live_valid);

  // A live transfer is captured only when it is being presented (master sees
  // HREADY high) and cannot go straight through in the same cycle.
  assign capture = live_valid & ~issue &
                   ((state == ST_IDLE) | ((state == ST_DATA) & HREADYM));

  // Control FSM: tracks whether a transfer is held for grant or in its data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (live_valid) begin
            state <= issue ? ST_DATA : ST_PEND;
          end
        end
        ST_PEND: begin
          if (issue) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADYM) begin
            if (!live_valid) begin
              state <= ST_IDLE;
            end else if (issue) begin
              state <= ST_DATA;
            end else begin
              state <= ST_PEND;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Hold register: loads on capture and stays frozen while the transfer waits.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_sel   <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= 2'b00;
      hold_write <= 1'b0;
      hold_size  <= 3'b000;
      hold_burst <= 3'b000;
      hold_prot  <= 4'b0000;
      hold_lock  <= 1'b0;
    end else if (capture) begin
      hold_sel   <= HSELS;
      hold_addr  <= HADDRS;
      hold_trans <= HTRANSS;
      hold_write <= HWRITES;
      hold_size  <= HSIZES;
      hold_burst <= HBURSTS;
      hold_prot  <= HPROTS;
      hold_lock  <= HMASTLOCKS;
    end
  end

  // Address-phase mux: replay the held transfer while pending, else pass through.
  assign HSELM      = pend ? hold_sel   : HSELS;
  assign HADDRM     = pend ? hold_addr  : HADDRS;
  assign HTRANSM    = pend ? hold_trans : HTRANSS;
  assign HWRITEM    = pend ? hold_write : HWRITES;
  assign HSIZEM     = pend ? hold_size  : HSIZES;
  assign HBURSTM    = pend ? hold_burst : HBURSTS;
  assign HPROTM     = pend ? hold_prot  : HPROTS;
  assign HMASTLOCKM = pend ? hold_lock  : HMASTLOCKS;

  // Stall the master while a transfer is held; otherwise forward the slave response.
  assign HREADYOUTS = pend ? 1'b0 : (dphase ? HREADYOUTM : 1'b1);
  assign HRESPS     = dphase ? HRESPM : 1'b0;

`ifdef AHB_MTX_IS_IDLE_REQ_EN
  // A locked master in an IDLE/BUSY gap keeps the arbiter parked on this port.
  logic lock_park;
  assign lock_park = HSELS & HMASTLOCKS & ~HTRANSS[1];
  assign req_port  = pend | live_valid | lock_park;
`else
  assign req_port  = pend | live_valid;
`endif

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// tb/tb_ahb_mtx_input_stage.sv - self-checking bench for ahb_mtx_input_stage with address scoreboard

module tb_ahb_mtx_input_stage;

  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          hsels;
  logic [AW-1:0] haddrs;
  logic [1:0]    htranss;
  logic          hwrites;
  logic [2:0]    hsizes;
  logic [2:0]    hbursts;
  logic [3:0]    hprots;
  logic          hmastlocks;
  logic          hreadys;
  logic          hreadyouts;
  logic          hresps;
  logic          hselm;
  logic [AW-1:0] haddrm;
  logic [1:0]    htransm;
  logic          hwritem;
  logic [2:0]    hsizem;
  logic [2:0]    hburstm;
  logic [3:0]    hprotm;
  logic          hmastlockm;
  logic          req_port;
  logic          addr_granted;
  logic          slv_ready;
  logic          hrespm;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef AHB_MTX_IS_IDLE_REQ_EN
  localparam logic [31:0] LOCK_REQ_EXP = 32'd1;
`else
  localparam logic [31:0] LOCK_REQ_EXP = 32'd0;
`endif

  // Single master, single slave: the master's HREADY is this stage's HREADYOUTS,
  // and the slave's ready drives both the port HREADY and HREADYOUTM.
  assign hreadys = hreadyouts;

  ahb_mtx_input_stage #(.AW(AW)) dut (
    .HCLK         (clk),
    .HRESET       (rst),
    .HSELS        (hsels),
    .HADDRS       (haddrs),
    .HTRANSS      (htranss),
    .HWRITES      (hwrites),
    .HSIZES       (hsizes),
    .HBURSTS      (hbursts),
    .HPROTS       (hprots),
    .HMASTLOCKS   (hmastlocks),
    .HREADYS      (hreadys),
    .HREADYOUTS   (hreadyouts),
    .HRESPS       (hresps),
    .HSELM        (hselm),
    .HADDRM       (haddrm),
    .HTRANSM      (htransm),
    .HWRITEM      (hwritem),
    .HSIZEM       (hsizem),
    .HBURSTM      (hburstm),
    .HPROTM       (hprotm),
    .HMASTLOCKM   (hmastlockm),
    .req_port     (req_port),
    .addr_granted (addr_granted),
    .HREADYM      (slv_ready),
    .HREADYOUTM   (slv_ready),
    .HRESPM       (hrespm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                       input logic wr, input logic [2:0] burst);
    hsels   = sel;
    haddrs  = addr;
    htranss = trans;
    hwrites = wr;
    hbursts = burst;
    hsizes  = 3'b010;
  endtask

  // Scoreboard: whenever the matrix accepts an address phase, it must be the next expected one.
  always @(negedge clk) begin
    if (!rst && hselm && htransm[1] && addr_granted && slv_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("sb_addr", haddrm, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    rst          = 1'b1;
    addr_granted = 1'b0;
    slv_ready    = 1'b1;
    hrespm       = 1'b0;
    hprots       = 4'b0011;
    hmastlocks   = 1'b0;
    drive(1'b0, 32'h0, T_IDLE, 1'b0, 3'b000);
    tick();
    tick();

    // Reset state
    check("rst_hreadyouts", 32'(hreadyouts), 32'd1);
    check("rst_hresps", 32'(hresps), 32'd0);
    check("rst_req", 32'(req_port), 32'd0);
    rst = 1'b0;
    tick();

    // 1: granted pass-through
    addr_granted = 1'b1;
    drive(1'b1, 32'h2000_0040, T_NONSEQ, 1'b1, 3'b000);
    exp_q.push_back(32'h2000_0040);
    #1;
    check("t1_haddrm", haddrm, 32'h2000_0040);
    check("t1_htransm", 32'(htransm), 32'(T_NONSEQ));
    check("t1_req", 32'(req_port), 32'd1);
    tick();
    drive(1'b0, 32'h0, T_IDLE, 1'b0, 3'b000);
    slv_ready = 1'b0;
    #1;
    check("t1_wait_hreadyouts", 32'(hreadyouts), 32'd0);
    tick();
    slv_ready = 1'b1;
    #1;
    check("t1_done_hreadyouts", 32'(hreadyouts), 32'd1);
    check("t1_hresps", 32'(hresps), 32'd0);
    tick();
    check("t1_idle_hreadyouts", 32'(hreadyouts), 32'd1);

    // 2: hold and replay
    addr_granted = 1'b0;
    drive(1'b1, 32'h2000_0100, T_NONSEQ, 1'b0, 3'b000);
    exp_q.push_back(32'h2000_0100);
    #1;
    check("t2_req", 32'(req_port), 32'd1);
    check("t2_pre_hreadyouts", 32'(hreadyouts), 32'd1);
    tick();
    drive(1'b1, 32'hDEAD_0000, T_IDLE, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_hreadyouts", 32'(hreadyouts), 32'd0);
      check("t2_hold_haddrm", haddrm, 32'h2000_0100);
      check("t2_hold_htransm", 32'(htransm), 32'(T_NONSEQ));
      check("t2_hold_hwritem", 32'(hwritem), 32'd0);
      check("t2_hold_req", 32'(req_port), 32'd1);
      tick();
    end
    addr_granted = 1'b1;
    #1;
    check("t2_issue_haddrm", haddrm, 32'h2000_0100);
    check("t2_issue_hreadyouts", 32'(hreadyouts), 32'd0);
    tick();
    check("t2_data_hreadyouts", 32'(hreadyouts), 32'd1);
    check("t2_data_hresps", 32'(hresps), 32'd0);
    tick();

    // 3: INCR4 with a hold on beat 2
    base = 32'h2000_0200;
    drive(1'b1, base, T_NONSEQ, 1'b1, 3'b011);
    exp_q.push_back(base);
    tick();
    drive(1'b1, base + 32'h4, T_SEQ, 1'b1, 3'b011);
    exp_q.push_back(base + 32'h4);
    tick();
    addr_granted = 1'b0;
    drive(1'b1, base + 32'h8, T_SEQ, 1'b1, 3'b011);
    exp_q.push_back(base + 32'h8);
    #1;
    check("t3_req", 32'(req_port), 32'd1);
    tick();
    drive(1'b1, base + 32'hC, T_SEQ, 1'b1, 3'b011);
    exp_q.push_back(base + 32'hC);
    check("t3_stall_hreadyouts", 32'(hreadyouts), 32'd0);
    check("t3_hold_haddrm", haddrm, base + 32'h8);
    tick();
    addr_granted = 1'b1;
    #1;
    check("t3_replay_haddrm", haddrm, base + 32'h8);
    check("t3_replay_hburstm", 32'(hburstm), 32'd3);
    tick();
    check("t3_beat3_hreadyouts", 32'(hreadyouts), 32'd1);
    check("t3_beat3_haddrm", haddrm, base + 32'hC);
    check("t3_beat3_htransm", 32'(htransm), 32'(T_SEQ));
    tick();
    drive(1'b0, 32'h0, T_IDLE, 1'b0, 3'b000);
    tick();
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: two-cycle ERROR forwarded, master goes IDLE
    drive(1'b1, 32'h2000_0300, T_NONSEQ, 1'b1, 3'b000);
    exp_q.push_back(32'h2000_0300);
    tick();
    drive(1'b1, 32'h0, T_IDLE, 1'b0, 3'b000);
    slv_ready = 1'b0;
    hrespm    = 1'b1;
    #1;
    check("t4_err1_hresps", 32'(hresps), 32'd1);
    check("t4_err1_hreadyouts", 32'(hreadyouts), 32'd0);
    tick();
    slv_ready = 1'b1;
    #1;
    check("t4_err2_hresps", 32'(hresps), 32'd1);
    check("t4_err2_hreadyouts", 32'(hreadyouts), 32'd1);
    tick();
    hrespm = 1'b0;
    #1;
    check("t4_idle_req", 32'(req_port), 32'd0);
    check("t4_idle_hresps", 32'(hresps), 32'd0);
    check("t4_idle_hreadyouts", 32'(hreadyouts), 32'd1);

    // 5: HREADYM low blocks issue from PEND, then reset drops the held transfer
    addr_granted = 1'b0;
    drive(1'b1, 32'h2000_0400, T_NONSEQ, 1'b0, 3'b000);
    tick();
    drive(1'b0, 32'h1111_0000, T_IDLE, 1'b0, 3'b000);
    addr_granted = 1'b1;
    slv_ready    = 1'b0;
    #1;
    check("t5_pend_hreadyouts", 32'(hreadyouts), 32'd0);
    tick();
    check("t5_noissue_hreadyouts", 32'(hreadyouts), 32'd0);
    check("t5_noissue_haddrm", haddrm, 32'h2000_0400);
    addr_granted = 1'b0;
    slv_ready    = 1'b1;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_hreadyouts", 32'(hreadyouts), 32'd1);
    check("t5_rst_req", 32'(req_port), 32'd0);
    check("t5_rst_haddrm", haddrm, 32'h1111_0000);
    check("t5_rst_htransm", 32'(htransm), 32'(T_IDLE));
    check("t5_rst_hselm", 32'(hselm), 32'd0);
    addr_granted = 1'b1;
    tick();
    check("t5_after_hreadyouts", 32'(hreadyouts), 32'd1);

    // 6: locked master idling
    hmastlocks = 1'b1;
    drive(1'b1, 32'h2000_0500, T_IDLE, 1'b0, 3'b000);
    #1;
    check("t6_lock_idle_req", 32'(req_port), LOCK_REQ_EXP);
    check("t6_hmastlockm", 32'(hmastlockm), 32'd1);
    htranss = T_BUSY;
    #1;
    check("t6_lock_busy_req", 32'(req_port), LOCK_REQ_EXP);
    hmastlocks = 1'b0;
    #1;
    check("t6_unlock_req", 32'(req_port), 32'd0);
    htranss = T_IDLE;
    tick();
    tick();

    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
